game_flow_controller: RTL and testbench

//  Top-level game sequencer for the Frogger design. Owns the level counter (1..99, BCD),
//  the lives counter and the play/respawn/game-over state machine.

---
 rtl/game_flow_controller_pkg.sv | 23 ++
 rtl/game_flow_controller_bcd_level_counter.sv | 43 ++++
 rtl/game_flow_controller.sv | 190 +++++++++++++++++++
 tb/tb_game_flow_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/game_flow_controller_pkg.sv
// Shared definitions for the Frogger game sequencer: state encodings, parameter
// defaults and a small lives helper.
package game_flow_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_LEVEL_UP  = 3'd2,
        ST_DEATH     = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_PAUSE     = 3'd5
    } game_state_e;

    localparam int DEF_START_LIVES   = 3;
    localparam int DEF_MAX_LEVEL     = 99;
    localparam int DEF_FREEZE_CYCLES = 12500000;

    // Lives saturate at zero instead of wrapping to 3.
    function automatic logic [1:0] dec_lives(input logic [1:0] lives);
        return (lives == 2'd0) ? 2'd0 : lives - 2'd1;
    endfunction

endpackage

// File: rtl/game_flow_controller_bcd_level_counter.sv
// Two-digit BCD level counter: clear to 01, increment with decimal carry,
// saturate at MAX_LEVEL.
module game_flow_controller_bcd_level_counter #(
    parameter int MAX_LEVEL = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_inc,
    output logic [3:0] o_tens,
    output logic [3:0] o_units
);

    localparam logic [3:0] MAX_TENS  = 4'(MAX_LEVEL / 10);
    localparam logic [3:0] MAX_UNITS = 4'(MAX_LEVEL % 10);

    logic [3:0] r_tens;
    logic [3:0] r_units;
    logic       w_at_max;

    assign w_at_max = (r_tens == MAX_TENS) && (r_units == MAX_UNITS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tens  <= 4'd0;
            r_units <= 4'd1;
        end else if (i_clear) begin
            r_tens  <= 4'd0;
            r_units <= 4'd1;
        end else if (i_inc && !w_at_max) begin
            if (r_units == 4'd9) begin
                r_units <= 4'd0;
                r_tens  <= r_tens + 4'd1;
            end else begin
                r_units <= r_units + 4'd1;
            end
        end
    end

    assign o_tens  = r_tens;
    assign o_units = r_units;

endmodule

// File: rtl/game_flow_controller.sv
// Frogger game sequencer: level/lives bookkeeping and the play/freeze/game-over FSM.
// Optional pause state enabled by defining GAME_PAUSE_EN.
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter int START_LIVES   = DEF_START_LIVES,
    parameter int MAX_LEVEL     = DEF_MAX_LEVEL,
    parameter int FREEZE_CYCLES = DEF_FREEZE_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_reset_all,
    input  logic       i_frog_at_top,
    input  logic       i_collision,
    input  logic       i_pause,
    output logic [2:0] o_state,
    output logic [3:0] o_level_tens,
    output logic [3:0] o_level_units,
    output logic [1:0] o_lives,
    output logic       o_reset_frog,
    output logic       o_freeze,
    output logic       o_game_over
);

    localparam int             FCW       = (FREEZE_CYCLES > 0) ? $clog2(FREEZE_CYCLES + 1) : 1;
    localparam logic [FCW-1:0] FRZ_LOAD  = FCW'((FREEZE_CYCLES > 0) ? FREEZE_CYCLES - 1 : 0);
    localparam logic [1:0]     LIVES_NEW = 2'(START_LIVES);

    game_state_e    r_state;
    logic [1:0]     r_lives;
    logic [FCW-1:0] r_freeze_cnt;
    logic           r_reset_frog;
    logic           r_freeze;
    logic           r_game_over;

    // Events are resampled once, then edge-detected against the previous sample.
    logic r_start_q, r_start_d;
    logic r_top_q, r_top_d;
    logic r_coll_q, r_coll_d;
    logic r_reset_all_d;
    logic w_start_rise, w_top_rise, w_coll_rise;
    logic w_level_clr, w_level_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_q     <= 1'b0;
            r_start_d     <= 1'b0;
            r_top_q       <= 1'b0;
            r_top_d       <= 1'b0;
            r_coll_q      <= 1'b0;
            r_coll_d      <= 1'b0;
            r_reset_all_d <= 1'b0;
        end else begin
            r_start_q     <= i_start;
            r_start_d     <= r_start_q;
            r_top_q       <= i_frog_at_top;
            r_top_d       <= r_top_q;
            r_coll_q      <= i_collision;
            r_coll_d      <= r_coll_q;
            r_reset_all_d <= i_reset_all;
        end
    end

    assign w_start_rise = r_start_q & ~r_start_d;
    assign w_top_rise   = r_top_q & ~r_top_d;
    assign w_coll_rise  = r_coll_q & ~r_coll_d;

`ifdef GAME_PAUSE_EN
    logic r_pause_q, r_pause_d;
    logic w_pause_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pause_q <= 1'b0;
            r_pause_d <= 1'b0;
        end else begin
            r_pause_q <= i_pause;
            r_pause_d <= r_pause_q;
        end
    end

    assign w_pause_rise = r_pause_q & ~r_pause_d;
`else
    logic w_unused_pause;
    assign w_unused_pause = i_pause;
`endif

    // Level control mirrors the FSM decisions so the digits change with the state.
    assign w_level_clr = i_reset_all ||
                         (((r_state == ST_IDLE) || (r_state == ST_GAME_OVER)) && w_start_rise);
    assign w_level_inc = !i_reset_all && (r_state == ST_PLAY) && w_top_rise && !w_coll_rise;

    game_flow_controller_bcd_level_counter #(
        .MAX_LEVEL (MAX_LEVEL)
    ) u_level (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_level_clr),
        .i_inc   (w_level_inc),
        .o_tens  (o_level_tens),
        .o_units (o_level_units)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_lives      <= LIVES_NEW;
            r_freeze_cnt <= '0;
            r_reset_frog <= 1'b0;
            r_freeze     <= 1'b1;
            r_game_over  <= 1'b0;
        end else begin
            r_reset_frog <= 1'b0;
            if (i_reset_all) begin
                r_state      <= ST_IDLE;
                r_lives      <= LIVES_NEW;
                r_freeze_cnt <= '0;
                r_freeze     <= 1'b1;
                r_game_over  <= 1'b0;
                r_reset_frog <= ~r_reset_all_d;
            end else begin
                case (r_state)
                    ST_IDLE, ST_GAME_OVER: begin
                        if (w_start_rise) begin
                            r_state      <= ST_PLAY;
                            r_lives      <= LIVES_NEW;
                            r_reset_frog <= 1'b1;
                            r_freeze     <= 1'b0;
                            r_game_over  <= 1'b0;
                        end
                    end
                    ST_PLAY: begin
                        // Collision beats a same-cycle arrival at the top row.
                        if (w_coll_rise) begin
                            r_freeze_cnt <= FRZ_LOAD;
                            r_freeze     <= 1'b1;
                            r_lives      <= dec_lives(r_lives);
                            if (r_lives <= 2'd1) begin
                                r_state     <= ST_GAME_OVER;
                                r_game_over <= 1'b1;
                            end else begin
                                r_state <= ST_DEATH;
                            end
                        end else if (w_top_rise) begin
                            r_state      <= ST_LEVEL_UP;
                            r_freeze_cnt <= FRZ_LOAD;
                            r_freeze     <= 1'b1;
                        end
`ifdef GAME_PAUSE_EN
                        else if (w_pause_rise) begin
                            r_state  <= ST_PAUSE;
                            r_freeze <= 1'b1;
                        end
`endif
                    end
                    ST_LEVEL_UP, ST_DEATH: begin
                        if (r_freeze_cnt == '0) begin
                            r_state      <= ST_PLAY;
                            r_freeze     <= 1'b0;
                            r_reset_frog <= 1'b1;
                        end else begin
                            r_freeze_cnt <= r_freeze_cnt - FCW'(1);
                        end
                    end
`ifdef GAME_PAUSE_EN
                    ST_PAUSE: begin
                        if (w_pause_rise) begin
                            r_state  <= ST_PLAY;
                            r_freeze <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        r_state     <= ST_IDLE;
                        r_freeze    <= 1'b1;
                        r_game_over <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_state      = r_state;
    assign o_lives      = r_lives;
    assign o_reset_frog = r_reset_frog;
    assign o_freeze     = r_freeze;
    assign o_game_over  = r_game_over;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with a 4-cycle freeze.
module tb_game_flow_controller;

    logic       clk;
    logic       reset;
    logic       i_start;
    logic       i_reset_all;
    logic       i_frog_at_top;
    logic       i_collision;
    logic       i_pause;
    logic [2:0] o_state;
    logic [3:0] o_level_tens;
    logic [3:0] o_level_units;
    logic [1:0] o_lives;
    logic       o_reset_frog;
    logic       o_freeze;
    logic       o_game_over;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [7:0] S_IDLE = 8'd0;
    localparam logic [7:0] S_PLAY = 8'd1;
    localparam logic [7:0] S_LVUP = 8'd2;
    localparam logic [7:0] S_DTH  = 8'd3;
    localparam logic [7:0] S_GOV  = 8'd4;

    game_flow_controller #(
        .START_LIVES   (3),
        .MAX_LEVEL     (99),
        .FREEZE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_reset_all   (i_reset_all),
        .i_frog_at_top (i_frog_at_top),
        .i_collision   (i_collision),
        .i_pause       (i_pause),
        .o_state       (o_state),
        .o_level_tens  (o_level_tens),
        .o_level_units (o_level_units),
        .o_lives       (o_lives),
        .o_reset_frog  (o_reset_frog),
        .o_freeze      (o_freeze),
        .o_game_over   (o_game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_level(input string tag, input int lvl);
        chk({tag, "_tens"}, 8'(o_level_tens), 8'(lvl / 10));
        chk({tag, "_units"}, 8'(o_level_units), 8'(lvl % 10));
    endtask

    // One-cycle input pulse, then one more cycle so the FSM reaction is visible.
    task automatic pulse(input logic top, input logic coll, input logic start);
        i_frog_at_top = top;
        i_collision   = coll;
        i_start       = start;
        @(negedge clk);
        i_frog_at_top = 1'b0;
        i_collision   = 1'b0;
        i_start       = 1'b0;
        @(negedge clk);
    endtask

    // Four frozen cycles, then PLAY with a single reset_frog pulse.
    task automatic ride_freeze(input string tag, input logic [7:0] frz_state);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk({tag, "_hold"}, 8'(o_state), frz_state);
            chk({tag, "_frz"}, 8'(o_freeze), 8'd1);
        end
        @(negedge clk);
        chk({tag, "_play"}, 8'(o_state), S_PLAY);
        chk({tag, "_rf"}, 8'(o_reset_frog), 8'd1);
        chk({tag, "_unfrz"}, 8'(o_freeze), 8'd0);
        @(negedge clk);
        chk({tag, "_rf_off"}, 8'(o_reset_frog), 8'd0);
    endtask

    task automatic level_up(input int exp_lvl);
        pulse(1'b1, 1'b0, 1'b0);
        chk("lu_state", 8'(o_state), S_LVUP);
        chk("lu_freeze", 8'(o_freeze), 8'd1);
        chk_level("lu_level", exp_lvl);
        ride_freeze("lu", S_LVUP);
    endtask

    task automatic death(input logic [7:0] exp_lives);
        pulse(1'b0, 1'b1, 1'b0);
        chk("dth_state", 8'(o_state), S_DTH);
        chk("dth_lives", 8'(o_lives), exp_lives);
        ride_freeze("dth", S_DTH);
    endtask

    task automatic start_game(input string tag);
        pulse(1'b0, 1'b0, 1'b1);
        chk({tag, "_state"}, 8'(o_state), S_PLAY);
        chk({tag, "_rf"}, 8'(o_reset_frog), 8'd1);
        chk({tag, "_lives"}, 8'(o_lives), 8'd3);
        chk({tag, "_freeze"}, 8'(o_freeze), 8'd0);
        chk({tag, "_gover"}, 8'(o_game_over), 8'd0);
        chk_level({tag, "_level"}, 1);
        @(negedge clk);
        chk({tag, "_rf_off"}, 8'(o_reset_frog), 8'd0);
    endtask

    initial begin
        reset         = 1'b1;
        i_start       = 1'b0;
        i_reset_all   = 1'b0;
        i_frog_at_top = 1'b0;
        i_collision   = 1'b0;
        i_pause       = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_state", 8'(o_state), S_IDLE);
        chk_level("rst_level", 1);
        chk("rst_lives", 8'(o_lives), 8'd3);
        chk("rst_rf", 8'(o_reset_frog), 8'd0);
        chk("rst_freeze", 8'(o_freeze), 8'd1);
        chk("rst_gover", 8'(o_game_over), 8'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_stays", 8'(o_state), S_IDLE);

        start_game("start1");

        // Nine level-ups: 02..10, crossing the units carry
        for (int lvl = 2; lvl <= 10; lvl++) level_up(lvl);
        chk("lvl10_tens", 8'(o_level_tens), 8'd1);
        chk("lvl10_units", 8'(o_level_units), 8'd0);

        // Three deaths, the last one ends the game
        death(8'd2);
        death(8'd1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("go_state", 8'(o_state), S_GOV);
        chk("go_flag", 8'(o_game_over), 8'd1);
        chk("go_lives", 8'(o_lives), 8'd0);
        chk("go_freeze", 8'(o_freeze), 8'd1);
        chk_level("go_level", 10);
        repeat (6) @(negedge clk);
        chk("go_stays", 8'(o_state), S_GOV);
        pulse(1'b1, 1'b0, 1'b0);
        chk("go_top_ignored", 8'(o_state), S_GOV);
        chk_level("go_top_level", 10);

        start_game("start2");

        // Climb to 99, then one more level-up must saturate
        for (int lvl = 2; lvl <= 99; lvl++) level_up(lvl);
        level_up(99);

        // Collision and top on the same cycle: collision wins
        pulse(1'b1, 1'b1, 1'b0);
        chk("both_state", 8'(o_state), S_DTH);
        chk("both_lives", 8'(o_lives), 8'd2);
        chk_level("both_level", 99);

        // Soft reset in the middle of the death freeze
        @(negedge clk);
        i_reset_all = 1'b1;
        @(negedge clk);
        chk("ra_state", 8'(o_state), S_IDLE);
        chk_level("ra_level", 1);
        chk("ra_lives", 8'(o_lives), 8'd3);
        chk("ra_rf", 8'(o_reset_frog), 8'd1);
        chk("ra_freeze", 8'(o_freeze), 8'd1);
        @(negedge clk);
        chk("ra_held_rf", 8'(o_reset_frog), 8'd0);
        chk("ra_held_state", 8'(o_state), S_IDLE);
        i_reset_all = 1'b0;
        repeat (6) @(negedge clk);
        chk("ra_after_state", 8'(o_state), S_IDLE);
        chk("ra_after_rf", 8'(o_reset_frog), 8'd0);

        // A held collision level counts once
        start_game("start3");
        level_up(2);
        i_collision = 1'b1;
        repeat (12) @(negedge clk);
        chk("held_coll_state", 8'(o_state), S_PLAY);
        chk("held_coll_lives", 8'(o_lives), 8'd2);
        i_collision = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-play takes effect without a clock edge
        #2 reset = 1'b1;
        #1;
        chk("arst_state", 8'(o_state), S_IDLE);
        chk_level("arst_level", 1);
        chk("arst_lives", 8'(o_lives), 8'd3);
        chk("arst_rf", 8'(o_reset_frog), 8'd0);
        chk("arst_freeze", 8'(o_freeze), 8'd1);
        chk("arst_gover", 8'(o_game_over), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_after", 8'(o_state), S_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
